vga_timing_gen: RTL and testbench

Pixel-timing stage directly downstream of the `clkgen` divider in the Vga subsystem. It takes the divided pixel clock `clkgen` produces, edge-detects it in the `clkin` domain to form a one-cycle pixel tick, and runs 640x480@60 horizontal and vertical counters on that tick. It issues pixel coordinates to the frame buffer and drives registered RGB, sync and valid outputs to the VGA pins.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_tick_gen.sv | 28 ++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants shared by the VGA timing stage.
package vga_pkg;

   localparam int unsigned CNT_W = 10;
   localparam int unsigned RGB_W = 8;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;

   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

endpackage

// File: rtl/vga_tick_gen.sv
// Rising-edge detector turning the divided pixel clock into a one-cycle tick.
module vga_tick_gen (
   input  logic clkin,
   input  logic rst,
   input  logic en,
   input  logic pclk,
   output logic tick
);

   logic pclk_d;
   // armed stays low until pclk has been seen low, so a pclk already high
   // when reset releases cannot masquerade as a rising edge.
   logic armed;

   // Sample pclk and track whether a low level has been observed.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         pclk_d <= 1'b0;
         armed  <= ~pclk;
      end else begin
         pclk_d <= pclk;
         armed  <= armed | ~pclk;
      end
   end

   assign tick = pclk & ~pclk_d & en & armed & rst;

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel counters, sync/active decode and registered VGA pin outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             en,
   input  logic             pclk,
   input  logic [23:0]      vga_data,
   output logic [CNT_W-1:0] h_addr,
   output logic [CNT_W-1:0] v_addr,
   output logic             pix_tick,
   output logic             hsync,
   output logic             vsync,
   output logic             valid,
   output logic [RGB_W-1:0] vga_r,
   output logic [RGB_W-1:0] vga_g,
   output logic [RGB_W-1:0] vga_b,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SB  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SE  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SB  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SE  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LST = CNT_W'(V_TOTAL - 1);

   logic             tick;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             active;
   logic             in_hs;
   logic             in_vs;

   vga_tick_gen u_tick (
      .clkin (clkin),
      .rst   (rst),
      .en    (en),
      .pclk  (pclk),
      .tick  (tick)
   );

   assign pix_tick = tick;

   // Phase decode and frame-buffer address from the current counters.
   always_comb begin
      active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      in_hs  = (h_cnt >= H_SB) && (h_cnt < H_SE);
      in_vs  = (v_cnt >= V_SB) && (v_cnt < V_SE);
      h_addr = active ? h_cnt : '0;
      v_addr = active ? v_cnt : '0;
   end

   // Horizontal/vertical position counters, advanced once per pixel tick.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_cnt == H_LST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LST) ? '0 : v_cnt + CNT_W'(1);
         end else begin
            h_cnt <= h_cnt + CNT_W'(1);
         end
      end
   end

   // Output register: captures the pixel addressed in the tick cycle, blanks when disabled.
   always_ff @(posedge clkin) begin
      if (!rst || !en) begin
         vga_r <= '0;
         vga_g <= '0;
         vga_b <= '0;
         valid <= 1'b0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (tick) begin
         vga_r <= active ? vga_data[23:16] : '0;
         vga_g <= active ? vga_data[15:8]  : '0;
         vga_b <= active ? vga_data[7:0]   : '0;
         valid <= active;
         hsync <= ~in_hs;
         vsync <= ~in_vs;
      end
   end

   // One-cycle marker aligned with pixel (0,0) reaching the pins.
   always_ff @(posedge clkin) begin
      if (!rst) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: stimulus queues per-tick expectations, monitor checks them.
module tb_vga_timing_gen;

   // Shortened vertical timing keeps whole-frame runs short; horizontal uses the 640x480 defaults.
   localparam int unsigned VA = 12;
   localparam int unsigned VFP = 2;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 4;
   localparam int unsigned VT = VA + VFP + VS + VB;
   localparam int unsigned HT = 800;

   logic        clkin = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        pclk = 1'b0;
   logic [23:0] vga_data;
   logic [9:0]  h_addr;
   logic [9:0]  v_addr;
   logic        pix_tick;
   logic        hsync;
   logic        vsync;
   logic        valid;
   logic [7:0]  vga_r;
   logic [7:0]  vga_g;
   logic [7:0]  vga_b;
   logic        frame_start;

   vga_timing_gen #(
      .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clkin       (clkin),
      .rst         (rst),
      .en          (en),
      .pclk        (pclk),
      .vga_data    (vga_data),
      .h_addr      (h_addr),
      .v_addr      (v_addr),
      .pix_tick    (pix_tick),
      .hsync       (hsync),
      .vsync       (vsync),
      .valid       (valid),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .frame_start (frame_start)
   );

   always #5 clkin = ~clkin;

   // Frame-buffer stand-in: colour is a fixed function of the address.
   function automatic logic [23:0] fb(input logic [9:0] h, input logic [9:0] v);
      return {h[7:0], v[7:0], h[9:2] ^ 8'h5A};
   endfunction

   assign vga_data = fb(h_addr, v_addr);

   typedef struct {
      logic [9:0]  h_addr;
      logic [9:0]  v_addr;
      logic        valid;
      logic        hsync;
      logic        vsync;
      logic        frame_start;
      logic [23:0] rgb;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   eh = 0;
   int   ev = 0;
   int   line_valid = 0;
   int   line_hs_low = 0;
   int   fs_count = 0;
   logic count_line = 1'b0;
   logic mon_on = 1'b0;

   function automatic exp_t expect_at(input int h, input int v);
      exp_t e;
      logic act;
      act           = (h < 640) && (v < int'(VA));
      e.h_addr      = act ? 10'(h) : 10'd0;
      e.v_addr      = act ? 10'(v) : 10'd0;
      e.valid       = act;
      e.hsync       = !((h >= 656) && (h < 752));
      e.vsync       = !((v >= int'(VA + VFP)) && (v < int'(VA + VFP + VS)));
      e.rgb         = act ? fb(10'(h), 10'(v)) : 24'h0;
      e.frame_start = (h == 0) && (v == 0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation on each pix_tick, checks outputs one clkin later.
   exp_t cur;
   logic out_pend = 1'b0;
   always @(negedge clkin) begin
      if (mon_on) begin
         if (out_pend) begin
            check("valid", 32'(valid), 32'(cur.valid));
            check("hsync", 32'(hsync), 32'(cur.hsync));
            check("vsync", 32'(vsync), 32'(cur.vsync));
            check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(cur.rgb));
            check("frame_start", 32'(frame_start), 32'(cur.frame_start));
            if (count_line) begin
               if (valid) line_valid++;
               if (!hsync) line_hs_low++;
            end
            if (frame_start) fs_count++;
            out_pend = 1'b0;
         end else begin
            check("frame_start_idle", 32'(frame_start), 32'd0);
         end
         if (pix_tick) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_tick: got pix_tick=1 expected no tick at %0t", $time);
            end else begin
               cur = q.pop_front();
               check("h_addr", 32'(h_addr), 32'(cur.h_addr));
               check("v_addr", 32'(v_addr), 32'(cur.v_addr));
               out_pend = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   // One pixel period of length div clkin cycles; queues the expected pixel.
   task automatic pix(input int div);
      q.push_back(expect_at(eh, ev));
      pclk = 1'b1;
      repeat (div / 2) step();
      pclk = 1'b0;
      repeat (div - div / 2) step();
      eh++;
      if (eh == int'(HT)) begin
         eh = 0;
         ev++;
         if (ev == int'(VT)) ev = 0;
      end
   endtask

   task automatic run_to(input int h, input int v);
      while (!((eh == h) && (ev == v))) pix(2);
   endtask

   task automatic check_blank(input string tag);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_hsync"}, 32'(hsync), 32'd1);
      check({tag, "_vsync"}, 32'(vsync), 32'd1);
      check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values.
      rst = 1'b0;
      en  = 1'b1;
      repeat (3) step();
      check_blank("reset");
      check("reset_h_addr", 32'(h_addr), 32'd0);
      check("reset_v_addr", 32'(v_addr), 32'd0);
      check("reset_fs", 32'(frame_start), 32'd0);
      rst = 1'b1;
      step();
      mon_on = 1'b1;

      // First pixels at clkin/4, then the rest of line 0 at clkin/2.
      count_line = 1'b1;
      repeat (10) pix(4);
      run_to(0, 1);
      count_line = 1'b0;
      check("line_valid_count", 32'(line_valid), 32'd640);
      check("line_hsync_low_count", 32'(line_hs_low), 32'd96);

      // Remainder of the frame, wrap to (0,0), a few pixels into the next frame.
      run_to(0, 0);
      repeat (5) pix(2);

      // Drop en mid-line at h_cnt=300 for 50 cycles while pclk keeps toggling.
      run_to(300, 0);
      en = 1'b0;
      step();
      step();
      check_blank("en_low");
      check("en_low_h_addr", 32'(h_addr), 32'd300);
      repeat (12) begin
         pclk = 1'b1;
         step();
         step();
         pclk = 1'b0;
         step();
         step();
      end
      en = 1'b1;
      repeat (3) pix(2);

      // Reset mid-frame at (700,10); hsync is low there before reset.
      run_to(700, 10);
      check("pre_reset_hsync", 32'(hsync), 32'd0);
      rst = 1'b0;
      step();
      check_blank("midreset");
      check("midreset_h_addr", 32'(h_addr), 32'd0);
      check("midreset_fs", 32'(frame_start), 32'd0);
      rst = 1'b1;
      eh = 0;
      ev = 0;
      repeat (4) pix(2);

      // pclk held high across reset release: no tick until it falls and rises.
      rst  = 1'b0;
      pclk = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      repeat (10) step();
      pclk = 1'b0;
      repeat (2) step();
      eh = 0;
      ev = 0;
      repeat (3) pix(2);

      repeat (4) step();
      check("queue_drained", 32'(q.size()), 32'd0);
      check("frame_start_total", 32'(fs_count), 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
